aclk_alarm_core: RTL



---
 rtl/aclk_alarm_core.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/aclk_alarm_core.sv
// Alarm-clock datapath: BCD HH:MM:SS timekeeping, HH:MM alarm register and latched Alarm.
// Define ACLK_LOAD_CHECK_EN to reject out-of-range loads and pulse load_err.
module aclk_alarm_core #(
    parameter int unsigned TICKS_PER_SEC = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] H_in1,
    input  logic [3:0] H_in0,
    input  logic [3:0] M_in1,
    input  logic [3:0] M_in0,
    input  logic       LD_time,
    input  logic       LD_alarm,
    input  logic       STOP_al,
    input  logic       AL_ON,
    output logic       Alarm,
    output logic [1:0] H_out1,
    output logic [3:0] H_out0,
    output logic [3:0] M_out1,
    output logic [3:0] M_out0,
    output logic [3:0] S_out1,
    output logic [3:0] S_out0,
    output logic       load_err
);

    localparam int unsigned CntW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TICKS_PER_SEC - 1);

    logic [CntW-1:0] cnt_q;
    logic            sec_tick;

    logic [1:0] h1_q, h1_n, ah1_q;
    logic [3:0] h0_q, h0_n, ah0_q;
    logic [3:0] m1_q, m1_n, am1_q;
    logic [3:0] m0_q, m0_n, am0_q;
    logic [3:0] s1_q, s1_n;
    logic [3:0] s0_q, s0_n;
    logic       alarm_q, alarm_d, alarm_set;
    logic       load_err_q, load_err_d;

    logic       s0_wrap, s1_wrap, m0_wrap, m1_wrap;
    logic       min_carry, hr_carry;
    logic [5:0] hour_val;

    logic       in_ok, ld_time_ok, ld_alarm_ok;

    assign sec_tick = (cnt_q == CntMax);
    assign hour_val = 6'(h1_q) * 6'd10 + {2'b00, h0_q};

    // Time one second ahead of the current registers.
    always_comb begin
        s0_wrap   = (s0_q >= 4'd9);
        s1_wrap   = (s1_q >= 4'd5);
        m0_wrap   = (m0_q >= 4'd9);
        m1_wrap   = (m1_q >= 4'd5);
        min_carry = s0_wrap & s1_wrap;
        hr_carry  = min_carry & m0_wrap & m1_wrap;

        s0_n = s0_wrap ? 4'd0 : s0_q + 4'd1;
        s1_n = s1_q;
        m0_n = m0_q;
        m1_n = m1_q;
        h1_n = h1_q;
        h0_n = h0_q;

        if (s0_wrap) begin
            s1_n = s1_wrap ? 4'd0 : s1_q + 4'd1;
        end
        if (min_carry) begin
            m0_n = m0_wrap ? 4'd0 : m0_q + 4'd1;
        end
        if (min_carry && m0_wrap) begin
            m1_n = m1_wrap ? 4'd0 : m1_q + 4'd1;
        end
        // An out-of-range hour (>= 24) is folded back to 00 on the very next second.
        if ((hour_val >= 6'd24) || (hr_carry && (hour_val >= 6'd23))) begin
            h1_n = 2'd0;
            h0_n = 4'd0;
        end else if (hr_carry) begin
            if (h0_q >= 4'd9) begin
                h0_n = 4'd0;
                h1_n = h1_q + 2'd1;
            end else begin
                h0_n = h0_q + 4'd1;
            end
        end
    end

`ifdef ACLK_LOAD_CHECK_EN
    logic [5:0] in_hour;
    assign in_hour = 6'(H_in1) * 6'd10 + {2'b00, H_in0};
    assign in_ok   = (H_in1 <= 2'd2) && (H_in0 <= 4'd9) && (in_hour <= 6'd23)
                   && (M_in1 <= 4'd5) && (M_in0 <= 4'd9);
    assign load_err_d = (LD_time | LD_alarm) & ~in_ok;
`else
    assign in_ok      = 1'b1;
    assign load_err_d = 1'b0;
`endif

    assign ld_time_ok  = LD_time & in_ok;
    assign ld_alarm_ok = LD_alarm & in_ok;

    always_comb begin
        alarm_set = sec_tick & ~ld_time_ok & ~ld_alarm_ok & AL_ON
                  & ({h1_n, h0_n, m1_n, m0_n, s1_n, s0_n}
                     == {ah1_q, ah0_q, am1_q, am0_q, 8'h00});
        alarm_d   = (STOP_al | ~AL_ON) ? 1'b0 : (alarm_q | alarm_set);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            h1_q       <= '0;
            h0_q       <= '0;
            m1_q       <= '0;
            m0_q       <= '0;
            s1_q       <= '0;
            s0_q       <= '0;
            ah1_q      <= '0;
            ah0_q      <= '0;
            am1_q      <= '0;
            am0_q      <= '0;
            alarm_q    <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            if (ld_time_ok) begin
                cnt_q <= '0;
                h1_q  <= H_in1;
                h0_q  <= H_in0;
                m1_q  <= M_in1;
                m0_q  <= M_in0;
                s1_q  <= 4'd0;
                s0_q  <= 4'd0;
            end else begin
                cnt_q <= sec_tick ? '0 : cnt_q + 1'b1;
                if (sec_tick) begin
                    h1_q <= h1_n;
                    h0_q <= h0_n;
                    m1_q <= m1_n;
                    m0_q <= m0_n;
                    s1_q <= s1_n;
                    s0_q <= s0_n;
                end
            end
            if (ld_alarm_ok) begin
                ah1_q <= H_in1;
                ah0_q <= H_in0;
                am1_q <= M_in1;
                am0_q <= M_in0;
            end
            alarm_q    <= alarm_d;
            load_err_q <= load_err_d;
        end
    end

    assign Alarm    = alarm_q;
    assign load_err = load_err_q;
    assign H_out1   = h1_q;
    assign H_out0   = h0_q;
    assign M_out1   = m1_q;
    assign M_out0   = m0_q;
    assign S_out1   = s1_q;
    assign S_out0   = s0_q;

endmodule
